// File: rtl/bin_to_bcd_disp_pkg.sv
// Shared constants and state encoding for the binary-to-BCD display converter.
package bin_to_bcd_disp_pkg;

  localparam int unsigned DISP_DIGITS     = 32'd8;
  localparam logic [3:0]  BCD_ADJ_THRESH  = 4'd5;
  localparam logic [3:0]  BCD_ADJ_ADD     = 4'd3;
  localparam logic [31:0] OVF_HEX_PATTERN = 32'hFFFF_FFFF;
  localparam logic [7:0]  DISP_OFF_ZERO   = 8'hFE;
  localparam int unsigned MAX_DISP_VALUE  = 32'd99_999_999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/bin_to_bcd_disp_bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
  import bin_to_bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  // Add-3 correction so the following left shift carries into the next digit
  always_comb begin
    if (digit >= BCD_ADJ_THRESH) begin
      adj = digit + BCD_ADJ_ADD;
    end else begin
      adj = digit;
    end
  end

endmodule

// File: rtl/bin_to_bcd_disp.sv
// Iterative binary-to-BCD converter with leading-zero blanking and overflow,
// feeding the 8-digit seven-segment driver through a START/BUSY/DONE handshake.
module bin_to_bcd_disp
  import bin_to_bcd_disp_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [BIN_W-1:0]      BIN_IN,
  input  logic                  LZB,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [4*DIGITS-1:0]   HEX_OUT,
  output logic [DIGITS-1:0]     DISP_OFF,
  output logic                  OVF
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [DIGITS-1:0] OFF_ZERO = DIGITS'(DISP_OFF_ZERO);
  localparam logic [BCD_W-1:0]  OVF_HEX  = BCD_W'(OVF_HEX_PATTERN);

  state_e             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [BIN_W-1:0]   sh_r;
  logic [BCD_W-1:0]   bcd_r;
  logic               lzb_r;
  logic               ovf_pend_r;

  logic [BCD_W-1:0]   adj_s;
  logic [DIGITS-1:0]  mask_s;
  logic               ovf_s;

  // Narrower inputs can never exceed the display range
  generate
    if (BIN_W >= 27) begin : g_ovf_cmp
      assign ovf_s = (BIN_IN > BIN_W'(MAX_DISP_VALUE));
    end else begin : g_ovf_none
      assign ovf_s = 1'b0;
    end
  endgenerate

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit (bcd_r[4*g +: 4]),
        .adj   (adj_s[4*g +: 4])
      );
    end
  endgenerate

  // Blank every digit above the most significant nonzero one; digit 0 always shows
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    mask_s  = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz   = seen_nz | (bcd_r[4*i +: 4] != 4'd0);
      mask_s[i] = lzb_r & ~seen_nz;
    end
  end

  // Conversion FSM with registered handshake and display outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      sh_r       <= '0;
      bcd_r      <= '0;
      lzb_r      <= 1'b0;
      ovf_pend_r <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      OVF        <= 1'b0;
      HEX_OUT    <= '0;
      DISP_OFF   <= OFF_ZERO;
    end else begin
      DONE <= 1'b0;
      case (state_r)
        IDLE: begin
          if (START) begin
            sh_r       <= BIN_IN;
            bcd_r      <= '0;
            lzb_r      <= LZB;
            ovf_pend_r <= ovf_s;
            cnt_r      <= CNT_W'(BIN_W);
            BUSY       <= 1'b1;
            state_r    <= SHIFT;
          end
        end
        SHIFT: begin
          // Carry out of the top digit falls off the truncating cast
          bcd_r <= BCD_W'({adj_s, sh_r[BIN_W-1]});
          sh_r  <= sh_r << 1;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            state_r <= COMMIT;
          end
        end
        COMMIT: begin
          if (ovf_pend_r) begin
            HEX_OUT  <= OVF_HEX;
            DISP_OFF <= '0;
            OVF      <= 1'b1;
          end else begin
            HEX_OUT  <= bcd_r;
            DISP_OFF <= mask_s;
            OVF      <= 1'b0;
          end
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          BUSY    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
